// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: ibus/dbus Wishbone ports plus the RAM port of the arbiter.
// Signal suffixes are from the arbiter's point of view (slave modport).
interface ram_port_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic                  i_cyc_i, i_stb_i;
    logic [31:0]           i_adr_i;
    logic [DATA_W-1:0]     i_dat_o;
    logic                  i_ack_o;
    logic                  d_cyc_i, d_stb_i, d_we_i;
    logic [31:0]           d_adr_i;
    logic [DATA_W/8-1:0]   d_sel_i;
    logic [DATA_W-1:0]     d_dat_i, d_dat_o;
    logic                  d_ack_o;
    logic                  ram_we_o;
    logic [ADDR_W-1:0]     ram_adr_o;
    logic [DATA_W/8-1:0]   ram_be_o;
    logic [DATA_W-1:0]     ram_dat_o, ram_dat_i;
    logic [1:0]            grant_o;

    modport slave (
        input  i_cyc_i, i_stb_i, i_adr_i, d_cyc_i, d_stb_i, d_we_i, d_adr_i, d_sel_i, d_dat_i, ram_dat_i,
        output i_dat_o, i_ack_o, d_dat_o, d_ack_o, ram_we_o, ram_adr_o, ram_be_o, ram_dat_o, grant_o
    );

    modport master (
        output i_cyc_i, i_stb_i, i_adr_i, d_cyc_i, d_stb_i, d_we_i, d_adr_i, d_sel_i, d_dat_i, ram_dat_i,
        input  i_dat_o, i_ack_o, d_dat_o, d_ack_o, ram_we_o, ram_adr_o, ram_be_o, ram_dat_o, grant_o
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin two-master Wishbone classic arbiter in front of a
// single-port RAM with 1-cycle registered read data (IDLE -> ACCESS -> RESP).
module ram_port_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    ram_port_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    localparam logic [1:0] G_NONE = 2'b00, G_I = 2'b01, G_D = 2'b10;

    state_t            state_q, state_d;
    logic [1:0]        gnt_q, gnt_d;
    logic              last_dbus_q, last_dbus_d;
    logic              abort_q, abort_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic              req_ib, req_db, is_d, own_cyc, ack;
    logic [ADDR_W-1:0] sel_adr;
    logic              unused_adr;

    assign req_ib  = bus.i_cyc_i & bus.i_stb_i;
    assign req_db  = bus.d_cyc_i & bus.d_stb_i;
    assign is_d    = gnt_q == G_D;
    assign sel_adr = is_d ? bus.d_adr_i[ADDR_W+1:2] : bus.i_adr_i[ADDR_W+1:2];
    assign own_cyc = is_d ? bus.d_cyc_i : bus.i_cyc_i;
    assign unused_adr = ^{bus.i_adr_i[31:ADDR_W+2], bus.i_adr_i[1:0],
                          bus.d_adr_i[31:ADDR_W+2], bus.d_adr_i[1:0]};

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_dbus_d = last_dbus_q;
        abort_d     = abort_q;
        adr_d       = adr_q;
        case (state_q)
            IDLE: if (req_ib | req_db) begin
                // on a tie the master that was not granted last wins
                gnt_d       = (req_db & (~req_ib | ~last_dbus_q)) ? G_D : G_I;
                last_dbus_d = gnt_d == G_D;
                abort_d     = 1'b0;
                state_d     = ACCESS;
            end
            ACCESS: begin
                adr_d   = sel_adr;
                abort_d = ~own_cyc;
                state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            state_q     <= IDLE;
            gnt_q       <= G_NONE;
            last_dbus_q <= 1'b0;
            abort_q     <= 1'b0;
            adr_q       <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_dbus_q <= last_dbus_d;
            abort_q     <= abort_d;
            adr_q       <= adr_d;
        end

    // a write issued in ACCESS completes even if the master aborts; only the ack is dropped
    assign ack           = state_q == RESP && own_cyc && !abort_q;
    assign bus.i_ack_o   = ack && gnt_q == G_I;
    assign bus.d_ack_o   = ack && gnt_q == G_D;
    assign bus.ram_we_o  = state_q == ACCESS && is_d && bus.d_we_i;
    assign bus.ram_be_o  = state_q != ACCESS ? '0 : is_d ? bus.d_sel_i : '1;
    assign bus.ram_adr_o = state_q == ACCESS ? sel_adr : adr_q;
    assign bus.ram_dat_o = bus.d_dat_i;
    assign bus.i_dat_o   = bus.ram_dat_i;
    assign bus.d_dat_o   = bus.ram_dat_i;
    assign bus.grant_o   = state_q == IDLE ? G_NONE : gnt_q;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed tests with a transaction-level model and RAM
// shadow checked every cycle, plus literal expectations for each scenario.
module tb_ram_port_arbiter;
    logic clk = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk = ~clk;

    ram_port_arbiter_if #(.ADDR_W(12), .DATA_W(32)) bus ();
    ram_port_arbiter #(.ADDR_W(12), .DATA_W(32)) dut (.clk_i(clk), .rst_i(rst_i), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        return i == 0 ? 32'h3C01A000 : i == 4 ? 32'h11223344 : 32'h0;
    endfunction

    logic [31:0] mem [4096];
    always @(posedge clk)
        if (rst_i) begin
            for (int i = 0; i < 4096; i++) mem[i] <= init_word(i);
        end else begin
            if (bus.ram_we_o)
                for (int b = 0; b < 4; b++)
                    if (bus.ram_be_o[b]) mem[bus.ram_adr_o][8*b +: 8] <= bus.ram_dat_o[8*b +: 8];
            bus.ram_dat_i <= mem[bus.ram_adr_o];
        end

    // model: a transaction takes three cycles (arbitrate, access, respond)
    int          m_phase;
    logic [1:0]  m_owner, m_last;
    logic        m_abort, m_wr;
    logic [11:0] m_adr;
    logic [31:0] m_rd;
    logic [31:0] shadow [4096];

    wire        req_i  = bus.i_cyc_i && bus.i_stb_i;
    wire        req_d  = bus.d_cyc_i && bus.d_stb_i;
    wire [1:0]  pick   = (req_i && req_d) ? ~m_last : req_d ? 2'b10 : 2'b01;
    wire        m_acc  = m_phase == 1;
    wire        m_rsp  = m_phase == 2;
    wire [1:0]  e_gnt  = m_phase == 0 ? 2'b00 : m_owner;
    wire        e_we   = m_acc && m_owner == 2'b10 && bus.d_we_i;
    wire [3:0]  e_be   = !m_acc ? 4'h0 : m_owner == 2'b10 ? bus.d_sel_i : 4'hF;
    wire [11:0] e_adr  = !m_acc ? m_adr : m_owner == 2'b10 ? bus.d_adr_i[13:2] : bus.i_adr_i[13:2];
    wire        e_iack = m_rsp && m_owner == 2'b01 && bus.i_cyc_i && !m_abort;
    wire        e_dack = m_rsp && m_owner == 2'b10 && bus.d_cyc_i && !m_abort;

    always @(posedge clk or posedge rst_i)
        if (rst_i) begin
            m_phase <= 0;
            m_owner <= 2'b00;
            m_last  <= 2'b01;
            m_abort <= 1'b0;
            m_wr    <= 1'b0;
            m_adr   <= '0;
            for (int i = 0; i < 4096; i++) shadow[i] <= init_word(i);
        end else if (m_phase == 0) begin
            if (req_i || req_d) begin
                m_owner <= pick;
                m_last  <= pick;
                m_phase <= 1;
            end
        end else if (m_phase == 1) begin
            m_adr   <= e_adr;
            m_rd    <= shadow[e_adr];
            m_wr    <= e_we;
            m_abort <= !(m_owner == 2'b10 ? bus.d_cyc_i : bus.i_cyc_i);
            m_phase <= 2;
            if (e_we)
                for (int b = 0; b < 4; b++)
                    if (bus.d_sel_i[b]) shadow[e_adr][8*b +: 8] <= bus.d_dat_i[8*b +: 8];
        end else begin
            m_phase <= 0;
        end

    always @(negedge clk)
        if (!rst_i) begin
            chk("grant", 32'(bus.grant_o), 32'(e_gnt));
            chk("ram_we", 32'(bus.ram_we_o), 32'(e_we));
            chk("ram_be", 32'(bus.ram_be_o), 32'(e_be));
            chk("ram_adr", 32'(bus.ram_adr_o), 32'(e_adr));
            chk("i_ack", 32'(bus.i_ack_o), 32'(e_iack));
            chk("d_ack", 32'(bus.d_ack_o), 32'(e_dack));
            if (e_iack) chk("i_dat", bus.i_dat_o, m_rd);
            if (e_dack && !m_wr) chk("d_dat", bus.d_dat_o, m_rd);
        end

    logic        a_we, r_iack, r_dack;
    logic [11:0] a_adr;
    logic [3:0]  a_be;
    logic [1:0]  a_gnt;
    logic [31:0] r_idat, r_ddat;
    int          ack_who[$], ack_cyc[$];

    task automatic drop_all();
        bus.i_cyc_i = 0; bus.i_stb_i = 0;
        bus.d_cyc_i = 0; bus.d_stb_i = 0; bus.d_we_i = 0;
    endtask

    // starts in an IDLE cycle just after the edge; returns just after the edge ending RESP
    task automatic xfer(input bit dbus, input bit we, input logic [31:0] adr,
                        input logic [3:0] sel, input logic [31:0] dat);
        if (dbus) begin
            bus.d_cyc_i = 1; bus.d_stb_i = 1; bus.d_we_i = we;
            bus.d_adr_i = adr; bus.d_sel_i = sel; bus.d_dat_i = dat;
        end else begin
            bus.i_cyc_i = 1; bus.i_stb_i = 1; bus.i_adr_i = adr;
        end
        @(negedge clk);
        @(negedge clk);
        a_we = bus.ram_we_o; a_adr = bus.ram_adr_o; a_be = bus.ram_be_o; a_gnt = bus.grant_o;
        @(negedge clk);
        r_iack = bus.i_ack_o; r_dack = bus.d_ack_o; r_idat = bus.i_dat_o; r_ddat = bus.d_dat_o;
        @(posedge clk); #1;
        drop_all();
    endtask

    task automatic record(input int cycles);
        ack_who.delete(); ack_cyc.delete();
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (bus.i_ack_o) begin ack_who.push_back(1); ack_cyc.push_back(c); end
            if (bus.d_ack_o) begin ack_who.push_back(2); ack_cyc.push_back(c); end
        end
    endtask

    initial begin
        drop_all();
        bus.i_adr_i = 0; bus.d_adr_i = 0; bus.d_sel_i = 0; bus.d_dat_i = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", 32'(bus.grant_o), 0);
        chk("rst_i_ack", 32'(bus.i_ack_o), 0);
        chk("rst_d_ack", 32'(bus.d_ack_o), 0);
        chk("rst_we", 32'(bus.ram_we_o), 0);
        chk("rst_be", 32'(bus.ram_be_o), 0);
        chk("rst_adr", 32'(bus.ram_adr_o), 0);
        @(posedge clk); #1 rst_i = 0;

        xfer(1, 1, 32'h10, 4'b0011, 32'hAABBCCDD);
        chk("t1_we", 32'(a_we), 1);
        chk("t1_adr", 32'(a_adr), 4);
        chk("t1_be", 32'(a_be), 32'b0011);
        chk("t1_gnt", 32'(a_gnt), 32'b10);
        chk("t1_dack", 32'(r_dack), 1);
        xfer(1, 0, 32'h10, 4'hF, 0);
        chk("t1_rd_ack", 32'(r_dack), 1);
        chk("t1_rd_dat", r_ddat, 32'h1122CCDD);

        xfer(0, 0, 32'h0, 0, 0);
        chk("t2_we", 32'(a_we), 0);
        chk("t2_gnt", 32'(a_gnt), 32'b01);
        chk("t2_iack", 32'(r_iack), 1);
        chk("t2_idat", r_idat, 32'h3C01A000);

        bus.d_we_i = 1;
        xfer(0, 0, 32'h10, 0, 0);
        chk("t4_we", 32'(a_we), 0);
        chk("t4_be", 32'(a_be), 32'hF);
        chk("t4_idat", r_idat, 32'h1122CCDD);

        bus.d_cyc_i = 1; bus.d_stb_i = 1; bus.d_we_i = 1;
        bus.d_adr_i = 32'h14; bus.d_sel_i = 4'hF; bus.d_dat_i = 32'hCAFEF00D;
        @(posedge clk); #1;
        bus.d_cyc_i = 0; bus.d_stb_i = 0;
        @(negedge clk);
        chk("t5_we", 32'(bus.ram_we_o), 1);
        chk("t5_adr", 32'(bus.ram_adr_o), 5);
        @(negedge clk);
        chk("t5_dack", 32'(bus.d_ack_o), 0);
        chk("t5_gnt_resp", 32'(bus.grant_o), 32'b10);
        @(negedge clk);
        chk("t5_gnt_idle", 32'(bus.grant_o), 0);
        chk("t5_mem", mem[5], 32'hCAFEF00D);
        @(posedge clk); #1 drop_all();

        rst_i = 1;
        @(posedge clk); @(posedge clk); #1 rst_i = 0;
        bus.i_cyc_i = 1; bus.i_stb_i = 1; bus.i_adr_i = 32'h0;
        bus.d_cyc_i = 1; bus.d_stb_i = 1; bus.d_we_i = 0; bus.d_adr_i = 32'h10; bus.d_sel_i = 4'hF;
        record(12);
        @(posedge clk); #1 drop_all();
        chk("t3_n", 32'(ack_who.size()), 4);
        chk("t3_who0", 32'(ack_who[0]), 2);
        chk("t3_who1", 32'(ack_who[1]), 1);
        chk("t3_who2", 32'(ack_who[2]), 2);
        chk("t3_who3", 32'(ack_who[3]), 1);
        chk("t3_cyc0", 32'(ack_cyc[0]), 2);
        chk("t3_cyc3", 32'(ack_cyc[3]), 11);

        bus.d_cyc_i = 1; bus.d_stb_i = 1; bus.d_we_i = 1;
        bus.d_adr_i = 32'h18; bus.d_sel_i = 4'hF; bus.d_dat_i = 32'h12345678;
        @(posedge clk); #2 rst_i = 1;
        #1;
        chk("t6_we", 32'(bus.ram_we_o), 0);
        chk("t6_be", 32'(bus.ram_be_o), 0);
        chk("t6_dack", 32'(bus.d_ack_o), 0);
        chk("t6_iack", 32'(bus.i_ack_o), 0);
        chk("t6_gnt", 32'(bus.grant_o), 0);
        @(posedge clk); #1 rst_i = 0;
        bus.d_we_i = 0; bus.d_adr_i = 32'h10;
        bus.i_cyc_i = 1; bus.i_stb_i = 1; bus.i_adr_i = 32'h0;
        record(3);
        @(posedge clk); #1 drop_all();
        chk("t6_n", 32'(ack_who.size()), 1);
        chk("t6_first", 32'(ack_who[0]), 2);
        chk("t6_cyc", 32'(ack_cyc[0]), 2);

        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
